// File: rtl/seg_pkg.sv
// Shared scan-state type and display constants for the seven-segment scanner.
// Anode and segment lines are active-low; AN_OFF/SEG_BLANK describe a dark display.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       AN_ON     = 1'b0;
    localparam logic       AN_OFF    = 1'b1;

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running 0..REFRESH_DIV-1 counter; tick is high for the single cycle at the top count.
// Latency: tick is decoded combinationally from the registered count; no backpressure.
module seg_tick_gen #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Captures UART bytes into a nibble buffer and scans it across NUM_DIGITS common-anode digits.
// Bytes land in the buffer on the strobe edge and show at each digit's next BLANK->DRIVE edge; no backpressure.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  clear,
    output logic [3:0]            nib_out,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int                    PTR_W      = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{AN_OFF}};
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

    logic [3:0]       nib_buf [NUM_DIGITS];
    logic [PTR_W-1:0] ptr;
    scan_state_t      state;
    logic             tick;

    seg_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Each byte pushes the display left by two digits; clear takes priority over a same-cycle byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_buf[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_buf[i] <= '0;
            end
        end else if (rx_ready) begin
            for (int i = NUM_DIGITS - 1; i >= 2; i--) begin
                nib_buf[i] <= nib_buf[i-2];
            end
            nib_buf[1] <= rx_data[7:4];
            nib_buf[0] <= rx_data[3:0];
        end
    end

    assign nib_out = nib_buf[ptr];

    // The decoder result is latched only when leaving BLANK, so the segments never change while a digit is lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BLANK;
            ptr   <= '0;
            an    <= AN_ALL_OFF;
            seg   <= SEG_BLANK;
        end else begin
            case (state)
                BLANK: begin
                    state <= DRIVE;
                    seg   <= seg_in;
                    an    <= ~(DIG_ONE << ptr);
                end
                DRIVE: begin
                    if (tick) begin
                        state <= BLANK;
                        an    <= AN_ALL_OFF;
                        if (ptr == PTR_W'(NUM_DIGITS - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
